// File: rtl/sha256_pkg.sv
// Shared definitions for the double-SHA256 nonce scheduler: state encoding,
// block geometry and the byte-swap helpers used on nonce and digest.
package sha256_pkg;

  localparam int HDR_W = 608;
  localparam int BLK_W = 640;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KICK  = 2'd1,
    S_WAIT  = 2'd2,
    S_CHECK = 2'd3
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] w);
    logic [255:0] r;
    r = {256{1'b0}};
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = w[8*(31-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_nonce_sched_if.sv
// Scheduler <-> hash core link: start/block toward the core, digest/done back.
interface sha256_nonce_sched_if;
  import sha256_pkg::*;

  logic             core_start;
  logic [BLK_W-1:0] core_block;
  logic [255:0]     core_hash;
  logic             core_done;

  modport master (output core_start, core_block, input core_hash, core_done);
  modport slave  (input core_start, core_block, output core_hash, core_done);
endinterface

// File: rtl/sha256_nonce_sched_hash_cmp.sv
// Converts the core digest to its little-endian numeric value and tests it
// against the target; kept separate so a pipelined comparator can replace it.
module hash_cmp
  import sha256_pkg::*;
(
  input  logic [255:0] core_hash,
  input  logic [255:0] target,
  output logic [255:0] hash_num,
  output logic         hit
);

  assign hash_num = bswap256(core_hash);
  assign hit      = (hash_num <= target);

endmodule

// File: rtl/sha256_nonce_sched.sv
// Nonce scheduler: walks a (possibly wrapping) nonce range through the hash
// core and stops on the first digest at or below the target.
module sha256_nonce_sched
  import sha256_pkg::*;
#(
  parameter int LAT_MIN = 200,
  parameter int LAT_MAX = 400,
  parameter int CNT_W   = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic                 abort,
  input  logic [HDR_W-1:0]     header,
  input  logic [31:0]          nonce_start,
  input  logic [31:0]          nonce_end,
  input  logic [255:0]         target,
  sha256_nonce_sched_if.master core,
  output logic                 busy,
  output logic                 found,
  output logic [31:0]          found_nonce,
  output logic [255:0]         found_hash,
  output logic                 exhausted,
  output logic                 timeout,
  output logic [31:0]          cur_nonce
);

  state_e             state_q, state_d;
  logic [HDR_W-1:0]   header_q, header_d;
  logic [31:0]        nonce_end_q, nonce_end_d;
  logic [255:0]       target_q, target_d;
  logic [31:0]        cur_nonce_q, cur_nonce_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               core_start_q, core_start_d;
  logic               busy_q, busy_d;
  logic               found_q, found_d;
  logic [31:0]        found_nonce_q, found_nonce_d;
  logic [255:0]       found_hash_q, found_hash_d;
  logic               exhausted_q, exhausted_d;
  logic               timeout_q, timeout_d;
  logic [255:0]       hash_num_s;
  logic               hit_s;
  logic               done_ok_s;

  hash_cmp u_cmp (
    .core_hash (core.core_hash),
    .target    (target_q),
    .hash_num  (hash_num_s),
    .hit       (hit_s)
  );

  // A done level is only trusted once the core has had LAT_MIN cycles.
  assign done_ok_s = core.core_done && (cnt_q >= CNT_W'(LAT_MIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (go) state_d = S_KICK; else state_d = S_IDLE;
        S_KICK:  state_d = S_WAIT;
        S_WAIT:  if (done_ok_s) state_d = S_CHECK;
                 else if (cnt_q == CNT_W'(LAT_MAX)) state_d = S_IDLE;
                 else state_d = S_WAIT;
        S_CHECK: if (hit_s || (cur_nonce_q == nonce_end_q)) state_d = S_IDLE;
                 else state_d = S_KICK;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    header_d      = header_q;
    nonce_end_d   = nonce_end_q;
    target_d      = target_q;
    cur_nonce_d   = cur_nonce_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    exhausted_d   = exhausted_q;
    timeout_d     = timeout_q;
    if (abort) begin
      cur_nonce_d = cur_nonce_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            header_d    = header;
            nonce_end_d = nonce_end;
            target_d    = target;
            cur_nonce_d = nonce_start;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            timeout_d   = 1'b0;
          end else begin
            cur_nonce_d = cur_nonce_q;
          end
        end
        S_WAIT: begin
          if (!done_ok_s && (cnt_q == CNT_W'(LAT_MAX))) timeout_d = 1'b1;
          else timeout_d = timeout_q;
        end
        S_CHECK: begin
          if (hit_s) begin
            found_d       = 1'b1;
            found_nonce_d = cur_nonce_q;
            found_hash_d  = hash_num_s;
          end else if (cur_nonce_q == nonce_end_q) begin
            exhausted_d = 1'b1;
          end else begin
            cur_nonce_d = cur_nonce_q + 32'd1;
          end
        end
        default: cur_nonce_d = cur_nonce_q;
      endcase
    end
    // cnt_q reads 0 during KICK and counts up through WAIT.
    if (state_d == S_KICK)      cnt_d = {CNT_W{1'b0}};
    else if (state_d == S_WAIT) cnt_d = cnt_q + CNT_W'(1);
    else                        cnt_d = cnt_q;
    core_start_d = (state_d == S_KICK);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      header_q      <= {HDR_W{1'b0}};
      nonce_end_q   <= 32'd0;
      target_q      <= 256'd0;
      cur_nonce_q   <= 32'd0;
      cnt_q         <= {CNT_W{1'b0}};
      core_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= 32'd0;
      found_hash_q  <= 256'd0;
      exhausted_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      header_q      <= header_d;
      nonce_end_q   <= nonce_end_d;
      target_q      <= target_d;
      cur_nonce_q   <= cur_nonce_d;
      cnt_q         <= cnt_d;
      core_start_q  <= core_start_d;
      busy_q        <= busy_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      exhausted_q   <= exhausted_d;
      timeout_q     <= timeout_d;
    end
  end

  assign core.core_start = core_start_q;
  assign core.core_block = {header_q, bswap32(cur_nonce_q)};
  assign busy            = busy_q;
  assign found           = found_q;
  assign found_nonce     = found_nonce_q;
  assign found_hash      = found_hash_q;
  assign exhausted       = exhausted_q;
  assign timeout         = timeout_q;
  assign cur_nonce       = cur_nonce_q;

endmodule
